hs_ram_arbiter: RTL and testbench

Arbitrates the game core's 2K×8 work-RAM port between the CPU bus and the hiscore save/restore engine. When the hiscore engine requests access, the arbiter asserts a pause request to the core and waits for the CPU to report halted. It then lets the bus settle, hands the RAM port to the hiscore side, and returns it to the CPU after a release delay. It sits between the hiscore module, the pause logic and the core's work-RAM instance, all in the `clk_sys` domain.

---
 rtl/hs_ram_arbiter_if.sv | 60 ++++++
 rtl/hs_ram_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_hs_ram_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// hs_ram_arbiter_if
//
// Purpose: bundles every bus signal around the work-RAM arbiter. This covers
// the CPU side, the hiscore side, the pause handshake and the shared RAM port.
//
// Modports:
//   slave  - the arbiter's view. It receives the cpu_*/hs_* requests,
//            cpu_halted and ram_dout. It drives cpu_dout, hs_ready, hs_dout,
//            hs_error, pause_req, ram_addr, ram_din and ram_we.
//   master - the surrounding system's view, with the opposite directions.
//
// Signals:
//   cpu_addr/cpu_din/cpu_we : CPU RAM request
//   cpu_dout                : RAM read data returned to the CPU
//   hs_addr/hs_din/hs_we    : hiscore RAM request
//   hs_access               : hiscore wants the port (level)
//   hs_ready                : hiscore currently owns the port
//   hs_dout                 : registered hiscore read data
//   hs_error                : one-cycle pulse when the halt wait times out
//   pause_req/cpu_halted    : pause handshake with the core
//   ram_addr/ram_din/ram_we : shared RAM port
//   ram_dout                : shared RAM read data (1-cycle synchronous read)
// ---------------------------------------------------------------------------
interface hs_ram_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 8
);
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_we;
    logic [DW-1:0] cpu_dout;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_din;
    logic          hs_we;
    logic          hs_access;
    logic          hs_ready;
    logic [DW-1:0] hs_dout;
    logic          hs_error;
    logic          pause_req;
    logic          cpu_halted;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  cpu_addr, cpu_din, cpu_we, hs_addr, hs_din, hs_we, hs_access,
               cpu_halted, ram_dout,
        output cpu_dout, hs_ready, hs_dout, hs_error, pause_req,
               ram_addr, ram_din, ram_we
    );

    modport master (
        output cpu_addr, cpu_din, cpu_we, hs_addr, hs_din, hs_we, hs_access,
               cpu_halted, ram_dout,
        input  cpu_dout, hs_ready, hs_dout, hs_error, pause_req,
               ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/hs_ram_arbiter.sv
// ---------------------------------------------------------------------------
// hs_ram_arbiter
//
// Purpose: shares the game core's work-RAM port between the CPU and the
// hiscore save/restore engine. When the hiscore side asks for the port, the
// arbiter pauses the CPU and waits for the halt acknowledge. It then lets the
// bus settle and hands the port over. After the hiscore side lets go, it holds
// the pause for a short release window before giving the port back to the CPU.
//
// Ports:
//   clk_sys : sole clock
//   reset   : synchronous, active-high
//   bus     : hs_ram_arbiter_if.slave, which carries the CPU, hiscore, pause
//             and RAM signals
//
// Parameters:
//   AW, DW  : RAM address / data width
//   SETTLE  : cycles between the halt acknowledge and the grant (>= 1)
//   RELEASE : cycles the pause is held after the hiscore side finishes (>= 1)
//   TIMEOUT : cycles to wait for cpu_halted before the request is aborted
// ---------------------------------------------------------------------------
module hs_ram_arbiter #(
    parameter int AW      = 11,
    parameter int DW      = 8,
    parameter int SETTLE  = 4,
    parameter int RELEASE = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic            clk_sys,
    input  logic            reset,
    hs_ram_arbiter_if.slave bus
);

    // One counter serves the settle wait, the release wait and the halt
    // timeout. It is sized for the largest of the three.
    localparam int CMAX_SR = (SETTLE > RELEASE) ? SETTLE : RELEASE;
    localparam int CMAX    = (TIMEOUT > CMAX_SR) ? TIMEOUT : CMAX_SR;
    localparam int CW      = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE - 1);
    localparam logic [CW-1:0] TIMEOUT_CNT  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_SAT      = {CW{1'b1}};

    typedef enum logic [2:0] {
        ST_CPU,
        ST_DRAIN,
        ST_SETTLE,
        ST_HS,
        ST_REL
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] w_cntInc;
    logic          r_owner;
    logic          w_owner;
    logic          r_pauseReq;
    logic          w_pauseReq;
    logic          r_hsReady;
    logic          w_hsReady;
    logic          r_hsError;
    logic          w_hsError;
    logic [DW-1:0] r_hsDout;
    logic          w_ramWe;
    logic [AW-1:0] w_ramAddr;
    logic [DW-1:0] w_ramDin;

    // The counter saturates instead of wrapping. A long wait therefore can
    // never alias back onto a short terminal count.
    assign w_cntInc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CW'(1);

    // Next-state and next-output logic. Every registered output is
    // recomputed here, so the register block below only has to copy the
    // values. hs_error defaults low, which makes it a single-cycle pulse.
    always_comb begin
        w_nextState = r_state;
        w_cnt       = w_cntInc;
        w_owner     = r_owner;
        w_pauseReq  = r_pauseReq;
        w_hsReady   = r_hsReady;
        w_hsError   = 1'b0;

        case (r_state)
            ST_CPU: begin
                w_cnt      = '0;
                w_owner    = 1'b0;
                w_pauseReq = 1'b0;
                w_hsReady  = 1'b0;
                if (bus.hs_access) begin
                    w_nextState = ST_DRAIN;
                    w_pauseReq  = 1'b1;
                end
            end

            ST_DRAIN: begin
                if (bus.cpu_halted) begin
                    w_nextState = ST_SETTLE;
                    w_cnt       = '0;
                end else if (!bus.hs_access) begin
                    w_nextState = ST_REL;
                    w_cnt       = '0;
                end else if (r_cnt == TIMEOUT_CNT) begin
                    w_nextState = ST_CPU;
                    w_cnt       = '0;
                    w_pauseReq  = 1'b0;
                    w_hsError   = 1'b1;
                end
            end

            ST_SETTLE: begin
                if (!bus.hs_access) begin
                    w_nextState = ST_REL;
                    w_cnt       = '0;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_nextState = ST_HS;
                    w_cnt       = '0;
                    w_owner     = 1'b1;
                    w_hsReady   = 1'b1;
                end
            end

            ST_HS: begin
                // cpu_halted is deliberately ignored here. Once granted,
                // the hiscore side keeps the port until it lets go.
                w_cnt = '0;
                if (!bus.hs_access) begin
                    w_nextState = ST_REL;
                    w_owner     = 1'b0;
                    w_hsReady   = 1'b0;
                end
            end

            ST_REL: begin
                // A request that re-appears here is not latched. The arbiter
                // always passes through CPU for at least one cycle, so the
                // CPU gets a cycle between grants.
                if (r_cnt == RELEASE_LAST) begin
                    w_nextState = ST_CPU;
                    w_cnt       = '0;
                    w_pauseReq  = 1'b0;
                end
            end

            default: begin
                w_nextState = ST_CPU;
                w_cnt       = '0;
                w_owner     = 1'b0;
                w_pauseReq  = 1'b0;
                w_hsReady   = 1'b0;
            end
        endcase
    end

    // State and output registers. The hiscore read data register samples the
    // RAM every cycle while the hiscore side owns the port. A read therefore
    // appears two edges after its address: one edge for the RAM, one for here.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= ST_CPU;
            r_cnt      <= '0;
            r_owner    <= 1'b0;
            r_pauseReq <= 1'b0;
            r_hsReady  <= 1'b0;
            r_hsError  <= 1'b0;
            r_hsDout   <= '0;
        end else begin
            r_state    <= w_nextState;
            r_cnt      <= w_cnt;
            r_owner    <= w_owner;
            r_pauseReq <= w_pauseReq;
            r_hsReady  <= w_hsReady;
            r_hsError  <= w_hsError;
            if (r_state == ST_HS) begin
                r_hsDout <= bus.ram_dout;
            end
        end
    end

    // Write-enable gating. The SETTLE and REL windows keep the RAM quiet
    // while ownership is changing hands. Outside those windows the
    // registered owner picks the source. In DRAIN the CPU still writes freely.
    always_comb begin
        w_ramWe = bus.cpu_we;
        if ((r_state == ST_SETTLE) || (r_state == ST_REL)) begin
            w_ramWe = 1'b0;
        end else if (r_owner) begin
            w_ramWe = bus.hs_we & bus.hs_access;
        end
    end

    assign w_ramAddr = r_owner ? bus.hs_addr : bus.cpu_addr;
    assign w_ramDin  = r_owner ? bus.hs_din  : bus.cpu_din;

    assign bus.ram_addr  = w_ramAddr;
    assign bus.ram_din   = w_ramDin;
    assign bus.ram_we    = w_ramWe;
    assign bus.cpu_dout  = bus.ram_dout;
    assign bus.hs_dout   = r_hsDout;
    assign bus.hs_ready  = r_hsReady;
    assign bus.hs_error  = r_hsError;
    assign bus.pause_req = r_pauseReq;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hs_ram_arbiter
//
// Purpose: self-checking bench for hs_ram_arbiter. It contains a 2Kx8
// synchronous-read RAM and the following stimulus:
//   - a cycle-by-cycle vector table for grant, release, back-to-back
//     requests and an abort out of SETTLE
//   - hand-written sequences for data transfer, timeout, abort in DRAIN and
//     reset during a grant
//   - randomized sessions scored against a memory model plus grant and
//     release timing derived from the arbiter's cycle budget
// ---------------------------------------------------------------------------
module tb_hs_ram_arbiter;

    localparam int AW      = 11;
    localparam int DW      = 8;
    localparam int SETTLE  = 4;
    localparam int RELEASE = 2;
    localparam int TIMEOUT = 15;

    logic clk_sys = 1'b0;
    logic reset;

    hs_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    hs_ram_arbiter #(
        .AW(AW), .DW(DW), .SETTLE(SETTLE), .RELEASE(RELEASE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    // 100 MHz-style free-running clock.
    always #5 clk_sys = ~clk_sys;

    // Work RAM with a read-first synchronous read port.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk_sys) begin
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= ram[bus.ram_addr];
    end

    int errors = 0;
    int checks = 0;

    // Expected memory contents. Only addresses that this bench has written
    // are ever compared.
    logic [DW-1:0] mdl [int];
    int            knownAddrs [$];

    typedef struct {
        logic acc;
        logic halted;
        logic expRamWe;
        logic expHsSel;
        logic expPause;
        logic expReady;
    } vec_t;

    vec_t vecs [$];

    localparam logic [AW-1:0] TBL_CPU_ADDR = 11'h7F0;
    localparam logic [AW-1:0] TBL_HS_ADDR  = 11'h7F1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic setIdle();
        bus.cpu_addr   = '0;
        bus.cpu_din    = '0;
        bus.cpu_we     = 1'b0;
        bus.hs_addr    = '0;
        bus.hs_din     = '0;
        bus.hs_we      = 1'b0;
        bus.hs_access  = 1'b0;
        bus.cpu_halted = 1'b0;
    endtask

    function automatic void addVec(logic a, logic h, logic w, logic s, logic p, logic r);
        vec_t v;
        v.acc = a; v.halted = h; v.expRamWe = w; v.expHsSel = s;
        v.expPause = p; v.expReady = r;
        vecs.push_back(v);
    endfunction

    function automatic void noteWrite(int a, logic [DW-1:0] d);
        if (!mdl.exists(a)) knownAddrs.push_back(a);
        mdl[a] = d;
    endfunction

    function automatic int pickKnown();
        return knownAddrs[$urandom_range(0, knownAddrs.size() - 1)];
    endfunction

    // Applies one table row. The combinational port outputs are checked
    // before the edge, and the registered handshake outputs after it.
    task automatic applyStimulus(input vec_t v, input int idx);
        bus.hs_access  = v.acc;
        bus.cpu_halted = v.halted;
        #1;
        checkOutput($sformatf("vec%0d ram_we", idx), 32'(bus.ram_we), 32'(v.expRamWe));
        checkOutput($sformatf("vec%0d ram_addr", idx), 32'(bus.ram_addr),
                    32'(v.expHsSel ? TBL_HS_ADDR : TBL_CPU_ADDR));
        tick();
        checkOutput($sformatf("vec%0d pause_req", idx), 32'(bus.pause_req), 32'(v.expPause));
        checkOutput($sformatf("vec%0d hs_ready", idx), 32'(bus.hs_ready), 32'(v.expReady));
        checkOutput($sformatf("vec%0d hs_error", idx), 32'(bus.hs_error), 32'h0);
    endtask

    task automatic cpuWrite(input int a, input logic [DW-1:0] d);
        bus.cpu_addr = AW'(a);
        bus.cpu_din  = d;
        bus.cpu_we   = 1'b1;
        tick();
        bus.cpu_we   = 1'b0;
        noteWrite(a, d);
    endtask

    task automatic cpuReadCheck(input int a, input string name);
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = AW'(a);
        tick();
        checkOutput(name, 32'(bus.cpu_dout), 32'(mdl[a]));
    endtask

    // Starts from idle with the CPU already halted. The grant must land
    // exactly 2+SETTLE edges after the request is first driven.
    task automatic grantNow(input string name);
        bus.hs_access  = 1'b1;
        bus.cpu_halted = 1'b1;
        tick();
        checkOutput({name, " pause_req"}, 32'(bus.pause_req), 32'h1);
        repeat (1 + SETTLE - 1) tick();
        checkOutput({name, " hs_ready early"}, 32'(bus.hs_ready), 32'h0);
        tick();
        checkOutput({name, " hs_ready"}, 32'(bus.hs_ready), 32'h1);
    endtask

    // One randomized session. The CPU writes during CPU/DRAIN and the halt
    // arrives after a random delay. The CPU keeps writing garbage while it
    // has no access, and the hiscore side does random writes and reads. Every
    // outcome is judged against the memory model and the fixed cycle budget.
    task automatic randSession(input int s);
        int d;
        int nOps;
        int a;
        logic [DW-1:0] dv;
        d    = $urandom_range(0, 4);
        nOps = $urandom_range(2, 6);

        bus.hs_access  = 1'b1;
        bus.cpu_halted = 1'b0;
        a  = $urandom_range(0, 11'h3FF);
        dv = DW'($urandom);
        bus.cpu_addr = AW'(a); bus.cpu_din = dv; bus.cpu_we = 1'b1;
        tick();
        noteWrite(a, dv);
        checkOutput($sformatf("rs%0d pause on", s), 32'(bus.pause_req), 32'h1);

        for (int i = 0; i <= d; i++) begin
            if (i == d) bus.cpu_halted = 1'b1;
            a  = $urandom_range(0, 11'h3FF);
            dv = DW'($urandom);
            bus.cpu_addr = AW'(a); bus.cpu_din = dv; bus.cpu_we = 1'b1;
            tick();
            noteWrite(a, dv);
            checkOutput($sformatf("rs%0d drain ready", s), 32'(bus.hs_ready), 32'h0);
        end

        for (int k = 1; k <= SETTLE; k++) begin
            bus.cpu_addr = AW'(pickKnown()); bus.cpu_din = DW'($urandom); bus.cpu_we = 1'b1;
            #1;
            checkOutput($sformatf("rs%0d settle ram_we", s), 32'(bus.ram_we), 32'h0);
            tick();
            checkOutput($sformatf("rs%0d settle ready k%0d", s, k), 32'(bus.hs_ready),
                        32'(k == SETTLE));
        end

        for (int op = 0; op < nOps; op++) begin
            bus.cpu_addr = AW'(pickKnown()); bus.cpu_din = DW'($urandom); bus.cpu_we = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                a  = $urandom_range(0, 11'h3FF);
                dv = DW'($urandom);
                bus.hs_addr = AW'(a); bus.hs_din = dv; bus.hs_we = 1'b1;
                tick();
                noteWrite(a, dv);
            end else begin
                a = pickKnown();
                bus.hs_addr = AW'(a); bus.hs_we = 1'b0;
                tick();
                tick();
                checkOutput($sformatf("rs%0d hs read 0x%0h", s, a), 32'(bus.hs_dout), 32'(mdl[a]));
            end
        end

        bus.hs_access = 1'b0;
        bus.hs_addr   = AW'(pickKnown()); bus.hs_din = DW'($urandom); bus.hs_we = 1'b1;
        tick();
        checkOutput($sformatf("rs%0d release ready", s), 32'(bus.hs_ready), 32'h0);
        for (int k = 1; k <= RELEASE; k++) begin
            #1;
            checkOutput($sformatf("rs%0d rel ram_we", s), 32'(bus.ram_we), 32'h0);
            tick();
            checkOutput($sformatf("rs%0d rel pause k%0d", s, k), 32'(bus.pause_req),
                        32'(k < RELEASE));
        end

        bus.cpu_we = 1'b0; bus.hs_we = 1'b0; bus.cpu_halted = 1'b0;
        for (int r = 0; r < 3; r++) begin
            a = pickKnown();
            cpuReadCheck(a, $sformatf("rs%0d readback 0x%0h", s, a));
        end
    endtask

    // Hard stop in case anything hangs.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        setIdle();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        checkOutput("reset pause_req", 32'(bus.pause_req), 32'h0);
        checkOutput("reset hs_ready", 32'(bus.hs_ready), 32'h0);
        checkOutput("reset hs_error", 32'(bus.hs_error), 32'h0);
        checkOutput("reset hs_dout", 32'(bus.hs_dout), 32'h0);
        bus.cpu_addr = 11'h2AA; bus.hs_addr = 11'h155; bus.cpu_we = 1'b1;
        #1;
        checkOutput("reset ram_addr is cpu", 32'(bus.ram_addr), 32'h2AA);
        checkOutput("reset ram_we is cpu", 32'(bus.ram_we), 32'h1);
        bus.cpu_we = 1'b0;
        tick();

        // Vector table: CPU and hiscore both try to write the whole time,
        // and each row states which side (if any) actually reaches the RAM.
        addVec(0,1, 1,0, 0,0);
        addVec(1,1, 1,0, 1,0);
        addVec(1,1, 1,0, 1,0);
        addVec(1,1, 0,0, 1,0);
        addVec(1,1, 0,0, 1,0);
        addVec(1,1, 0,0, 1,0);
        addVec(1,1, 0,0, 1,1);
        addVec(1,1, 1,1, 1,1);
        addVec(0,1, 0,1, 1,0);
        addVec(0,1, 0,0, 1,0);
        addVec(0,1, 0,0, 0,0);
        addVec(1,1, 1,0, 1,0);
        addVec(1,1, 1,0, 1,0);
        addVec(1,1, 0,0, 1,0);
        addVec(1,1, 0,0, 1,0);
        addVec(1,1, 0,0, 1,0);
        addVec(1,1, 0,0, 1,1);
        addVec(0,1, 0,1, 1,0);
        addVec(1,1, 0,0, 1,0);
        addVec(1,1, 0,0, 0,0);
        addVec(1,1, 1,0, 1,0);
        addVec(0,1, 1,0, 1,0);
        addVec(0,1, 0,0, 1,0);
        addVec(0,1, 0,0, 1,0);
        addVec(0,1, 0,0, 0,0);

        bus.cpu_addr = TBL_CPU_ADDR; bus.cpu_din = 8'h5A; bus.cpu_we = 1'b1;
        bus.hs_addr  = TBL_HS_ADDR;  bus.hs_din  = 8'h6B; bus.hs_we  = 1'b1;
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);
        setIdle();
        tick();

        // Basic grant, hiscore write/read of 0xA5, then release and a CPU write.
        grantNow("basic");
        bus.hs_addr = 11'h123; bus.hs_din = 8'hA5; bus.hs_we = 1'b1;
        tick();
        bus.hs_we = 1'b0;
        tick();
        tick();
        checkOutput("basic hs_dout", 32'(bus.hs_dout), 32'hA5);
        bus.hs_access = 1'b0;
        tick();
        checkOutput("release hs_ready", 32'(bus.hs_ready), 32'h0);
        checkOutput("release pause hold", 32'(bus.pause_req), 32'h1);
        tick();
        checkOutput("release pause hold2", 32'(bus.pause_req), 32'h1);
        tick();
        checkOutput("release pause off", 32'(bus.pause_req), 32'h0);
        cpuWrite(11'h123, 8'h3C);
        cpuReadCheck(11'h123, "release cpu_dout");

        // Timeout: the CPU never halts. hs_we is held high but must never
        // reach the RAM.
        bus.cpu_halted = 1'b0; bus.hs_access = 1'b1; bus.hs_we = 1'b1;
        bus.hs_addr = TBL_HS_ADDR; bus.cpu_we = 1'b0;
        tick();
        checkOutput("timeout pause on", 32'(bus.pause_req), 32'h1);
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            #1;
            checkOutput($sformatf("timeout ram_we k%0d", k), 32'(bus.ram_we), 32'h0);
            tick();
            checkOutput($sformatf("timeout hs_error k%0d", k), 32'(bus.hs_error),
                        32'(k == TIMEOUT + 1));
            checkOutput($sformatf("timeout pause k%0d", k), 32'(bus.pause_req),
                        32'(k <= TIMEOUT));
        end
        bus.hs_access = 1'b0; bus.hs_we = 1'b0;
        tick();
        checkOutput("timeout error one cycle", 32'(bus.hs_error), 32'h0);
        checkOutput("timeout back in cpu", 32'(bus.pause_req), 32'h0);
        tick();

        // Abort in DRAIN: the request goes away before any halt.
        bus.hs_access = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("abort drain ready", 32'(bus.hs_ready), 32'h0);
        bus.hs_access = 1'b0;
        tick();
        checkOutput("abort rel pause", 32'(bus.pause_req), 32'h1);
        checkOutput("abort rel ready", 32'(bus.hs_ready), 32'h0);
        tick();
        checkOutput("abort rel pause2", 32'(bus.pause_req), 32'h1);
        tick();
        checkOutput("abort pause off", 32'(bus.pause_req), 32'h0);
        checkOutput("abort ready never", 32'(bus.hs_ready), 32'h0);

        // Reset during a grant while the hiscore side is writing.
        grantNow("rst");
        bus.cpu_addr = 11'h200; bus.cpu_we = 1'b0;
        bus.hs_addr = 11'h055; bus.hs_din = 8'h99; bus.hs_we = 1'b1;
        tick();
        noteWrite(11'h055, 8'h99);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.hs_din = 8'h77; bus.hs_access = 1'b0;
        #1;
        checkOutput("rst hs_ready", 32'(bus.hs_ready), 32'h0);
        checkOutput("rst pause_req", 32'(bus.pause_req), 32'h0);
        checkOutput("rst hs_dout", 32'(bus.hs_dout), 32'h0);
        checkOutput("rst owner cpu", 32'(bus.ram_addr), 32'h200);
        checkOutput("rst ram_we cpu", 32'(bus.ram_we), 32'h0);
        tick();
        tick();
        bus.hs_we = 1'b0; bus.cpu_halted = 1'b0;
        cpuReadCheck(11'h055, "rst no late hs write");

        // Randomized sessions.
        for (int i = 0; i < 8; i++) cpuWrite($urandom_range(0, 11'h3FF), DW'($urandom));
        for (int s = 0; s < 25; s++) randSession(s);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
